// File: rtl/micro_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer_pkg
// Description : Shared definitions for the ARC control-store sequencer:
//               microword field positions, COND encodings, FSM state
//               encodings, the reset address and the decode-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_sequencer_pkg;

    // Microword field positions (41-bit word, MSB to LSB)
    localparam int c_UW_A_HI     = 40;
    localparam int c_UW_A_LO     = 35;
    localparam int c_UW_AMUX     = 34;
    localparam int c_UW_B_HI     = 33;
    localparam int c_UW_B_LO     = 28;
    localparam int c_UW_BMUX     = 27;
    localparam int c_UW_C_HI     = 26;
    localparam int c_UW_C_LO     = 21;
    localparam int c_UW_CMUX     = 20;
    localparam int c_UW_RD       = 19;
    localparam int c_UW_WR       = 18;
    localparam int c_UW_ALU_HI   = 17;
    localparam int c_UW_ALU_LO   = 14;
    localparam int c_UW_COND_HI  = 13;
    localparam int c_UW_COND_LO  = 11;
    localparam int c_UW_JADDR_HI = 10;
    localparam int c_UW_JADDR_LO = 0;

    // COND encodings
    localparam logic [2:0] c_COND_NEXT   = 3'b000;
    localparam logic [2:0] c_COND_N      = 3'b001;
    localparam logic [2:0] c_COND_Z      = 3'b010;
    localparam logic [2:0] c_COND_V      = 3'b011;
    localparam logic [2:0] c_COND_C      = 3'b100;
    localparam logic [2:0] c_COND_IR13   = 3'b101;
    localparam logic [2:0] c_COND_JUMP   = 3'b110;
    localparam logic [2:0] c_COND_DECODE = 3'b111;

    // Sequencer FSM state encodings
    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    // Control-store address used at reset and after a watchdog abort
    localparam logic [10:0] c_RESET_ADDR = 11'd0;

    // Instruction decode dispatch: the op and op3 fields of the instruction
    // select one of 256 entry points in the upper half of the control store,
    // spaced four words apart.
    function automatic logic [10:0] f_decode_addr(input logic [1:0] op,
                                                  input logic [5:0] op3);
        return {1'b1, op, op3, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer_next_addr
// Description : Purely combinational next control-store address select.
//               Chooses between CSAR+1 (modulo 2^ADDR_W), the microword's
//               jump address, or the instruction decode dispatch address.
// Ports       : i_cond       COND field of the current microword
//               i_jaddr      JADDR field of the current microword
//               i_csar       current control-store address
//               i_psr_nzvc   datapath flags {n,z,v,c}
//               i_ir_op      IR[31:30]
//               i_ir_op3     IR[24:19]
//               i_ir_bit13   IR[13]
//               o_next_addr  selected next address
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer_next_addr
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [2:0]        i_cond,
    input  logic [ADDR_W-1:0] i_jaddr,
    input  logic [ADDR_W-1:0] i_csar,
    input  logic [3:0]        i_psr_nzvc,
    input  logic [1:0]        i_ir_op,
    input  logic [5:0]        i_ir_op3,
    input  logic              i_ir_bit13,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_seq_addr;

    // Natural overflow of the adder gives the required wrap from the top
    // of the control store back to address 0.
    assign w_seq_addr = i_csar + 1'b1;

    always_comb begin
        o_next_addr = w_seq_addr;
        case (i_cond)
            c_COND_NEXT:   o_next_addr = w_seq_addr;
            c_COND_N:      o_next_addr = i_psr_nzvc[3] ? i_jaddr : w_seq_addr;
            c_COND_Z:      o_next_addr = i_psr_nzvc[2] ? i_jaddr : w_seq_addr;
            c_COND_V:      o_next_addr = i_psr_nzvc[1] ? i_jaddr : w_seq_addr;
            c_COND_C:      o_next_addr = i_psr_nzvc[0] ? i_jaddr : w_seq_addr;
            c_COND_IR13:   o_next_addr = i_ir_bit13    ? i_jaddr : w_seq_addr;
            c_COND_JUMP:   o_next_addr = i_jaddr;
            c_COND_DECODE: o_next_addr = ADDR_W'(f_decode_addr(i_ir_op, i_ir_op3));
            default:       o_next_addr = w_seq_addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Control-store sequencer for the ARC microarchitecture. Owns
//               the control-store address register (CSAR), the microcode
//               instruction register (MIR), the LOAD/EXEC/WAIT FSM and the
//               memory-wait watchdog.
// Ports       : CLOCK_50     system clock, rising edge
//               RESET_InLow  asynchronous active-low reset
//               CS_ADDR      CSAR, to ROM address input
//               CS_WORD      microword from ROM (combinational from CS_ADDR)
//               IR_BITS      instruction register contents
//               PSR_NZVC     datapath flags {n,z,v,c}
//               MEM_ACK      memory completion (pulse or level)
//               MEM_RD/WR    memory read/write requests (level)
//               DP_EN        datapath commit strobe, one cycle per microword
//               MIR_*        registered microword fields to the datapath
//               WD_ERR       sticky watchdog abort flag
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int DATA_BUS_ADDR = 11,
    parameter int DATA_BUS_WORD = 41,
    parameter int WAIT_MAX      = 255
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_InLow,
    output logic [DATA_BUS_ADDR-1:0] CS_ADDR,
    input  logic [DATA_BUS_WORD-1:0] CS_WORD,
    input  logic [31:0]              IR_BITS,
    input  logic [3:0]               PSR_NZVC,
    input  logic                     MEM_ACK,
    output logic                     MEM_RD,
    output logic                     MEM_WR,
    output logic                     DP_EN,
    output logic [5:0]               MIR_A,
    output logic [5:0]               MIR_B,
    output logic [5:0]               MIR_C,
    output logic                     MIR_AMUX,
    output logic                     MIR_BMUX,
    output logic                     MIR_CMUX,
    output logic [3:0]               MIR_ALU,
    output logic                     WD_ERR
);

    // Wait counter only needs to reach WAIT_MAX-1
    localparam int c_WD_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [1:0]               r_state;
    logic [DATA_BUS_ADDR-1:0] r_csar;
    logic [DATA_BUS_WORD-1:0] r_mir;
    logic [c_WD_W-1:0]        r_wd_cnt;
    logic                     r_wd_err;

    logic [DATA_BUS_ADDR-1:0] w_next_addr;
    logic                     w_mir_rd;
    logic                     w_mir_wr;
    logic                     w_mem_op;
    logic                     w_in_exec;
    logic                     w_in_wait;
    logic                     w_wd_expire;
    logic                     w_unused_ir;

    assign w_mir_rd  = r_mir[c_UW_RD];
    assign w_mir_wr  = r_mir[c_UW_WR];
    assign w_mem_op  = w_mir_rd | w_mir_wr;
    assign w_in_exec = (r_state == c_ST_EXEC);
    assign w_in_wait = (r_state == c_ST_WAIT);

    // Only the op, op3 and i fields of the instruction steer sequencing
    assign w_unused_ir = ^{IR_BITS[29:25], IR_BITS[18:14], IR_BITS[12:0]};

    // The watchdog fires in the WAIT_MAX-th consecutive WAIT cycle without ACK
    generate
        if (WAIT_MAX > 0) begin : g_wd_on
            assign w_wd_expire = (r_wd_cnt == c_WD_LAST);
        end else begin : g_wd_off
            assign w_wd_expire = 1'b0;
        end
    endgenerate

    micro_sequencer_next_addr #(
        .ADDR_W (DATA_BUS_ADDR)
    ) u_next_addr (
        .i_cond      (r_mir[c_UW_COND_HI:c_UW_COND_LO]),
        .i_jaddr     (r_mir[c_UW_JADDR_HI:c_UW_JADDR_LO]),
        .i_csar      (r_csar),
        .i_psr_nzvc  (PSR_NZVC),
        .i_ir_op     (IR_BITS[31:30]),
        .i_ir_op3    (IR_BITS[24:19]),
        .i_ir_bit13  (IR_BITS[13]),
        .o_next_addr (w_next_addr)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            r_state  <= c_ST_LOAD;
            r_csar   <= DATA_BUS_ADDR'(c_RESET_ADDR);
            r_mir    <= '0;
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    r_mir   <= CS_WORD;
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    r_wd_cnt <= '0;
                    if (w_mem_op) begin
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_csar  <= w_next_addr;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_WAIT: begin
                    // A completing ACK wins over a watchdog expiry in the same cycle
                    if (MEM_ACK) begin
                        r_csar  <= w_next_addr;
                        r_state <= c_ST_LOAD;
                    end else if (w_wd_expire) begin
                        r_wd_err <= 1'b1;
                        r_csar   <= DATA_BUS_ADDR'(c_RESET_ADDR);
                        r_state  <= c_ST_LOAD;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

    // Strobes are decoded from the registered state so an asynchronous reset
    // (which forces LOAD) removes them without waiting for a clock edge.
    // RD=WR=1 is treated as a read.
    assign MEM_RD = (w_in_exec | w_in_wait) & w_mir_rd;
    assign MEM_WR = (w_in_exec | w_in_wait) & w_mir_wr & ~w_mir_rd;
    assign DP_EN  = (w_in_exec & ~w_mem_op) | (w_in_wait & MEM_ACK);

    assign CS_ADDR  = r_csar;
    assign WD_ERR   = r_wd_err;
    assign MIR_A    = r_mir[c_UW_A_HI:c_UW_A_LO];
    assign MIR_AMUX = r_mir[c_UW_AMUX];
    assign MIR_B    = r_mir[c_UW_B_HI:c_UW_B_LO];
    assign MIR_BMUX = r_mir[c_UW_BMUX];
    assign MIR_C    = r_mir[c_UW_C_HI:c_UW_C_LO];
    assign MIR_CMUX = r_mir[c_UW_CMUX];
    assign MIR_ALU  = r_mir[c_UW_ALU_HI:c_UW_ALU_LO];

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer with a behavioural
//               ROM and a microword-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    localparam int c_WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cs_addr;
    logic [40:0] cs_word;
    logic [31:0] ir_bits;
    logic [3:0]  psr_nzvc;
    logic        mem_ack;
    logic        mem_rd;
    logic        mem_wr;
    logic        dp_en;
    logic [5:0]  mir_a;
    logic [5:0]  mir_b;
    logic [5:0]  mir_c;
    logic        mir_amux;
    logic        mir_bmux;
    logic        mir_cmux;
    logic [3:0]  mir_alu;
    logic        wd_err;

    logic [40:0] rom [0:2047];
    assign cs_word = rom[cs_addr];

    always #5 clk = ~clk;

    micro_sequencer #(
        .DATA_BUS_ADDR (11),
        .DATA_BUS_WORD (41),
        .WAIT_MAX      (c_WAIT_MAX)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_InLow (rst_n),
        .CS_ADDR     (cs_addr),
        .CS_WORD     (cs_word),
        .IR_BITS     (ir_bits),
        .PSR_NZVC    (psr_nzvc),
        .MEM_ACK     (mem_ack),
        .MEM_RD      (mem_rd),
        .MEM_WR      (mem_wr),
        .DP_EN       (dp_en),
        .MIR_A       (mir_a),
        .MIR_B       (mir_b),
        .MIR_C       (mir_c),
        .MIR_AMUX    (mir_amux),
        .MIR_BMUX    (mir_bmux),
        .MIR_CMUX    (mir_cmux),
        .MIR_ALU     (mir_alu),
        .WD_ERR      (wd_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: address of the next microword to load, sticky watchdog
    logic [10:0] m_csar;
    logic        m_wd;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [40:0] mk_word(input logic rd, input logic wr, input logic [5:0] c,
                                            input logic [2:0] cond, input logic [10:0] j);
        logic [40:0] w;
        w = {9'($urandom), $urandom};
        w[26:21] = c;
        w[19]    = rd;
        w[18]    = wr;
        w[13:11] = cond;
        w[10:0]  = j;
        return w;
    endfunction

    // Next address from the microword's COND/JADDR and the committing-cycle inputs
    function automatic logic [10:0] ref_next(input logic [40:0] w, input logic [10:0] csar,
                                             input logic [3:0] f, input logic [31:0] ir);
        int seq;
        bit take;
        seq = (int'(csar) + 1) % 2048;
        take = 1'b0;
        case (w[13:11])
            3'd0: take = 1'b0;
            3'd1: take = f[3];
            3'd2: take = f[2];
            3'd3: take = f[1];
            3'd4: take = f[0];
            3'd5: take = ir[13];
            3'd6: take = 1'b1;
            default: return {1'b1, ir[31:30], ir[24:19], 2'b00};
        endcase
        return take ? w[10:0] : 11'(seq);
    endfunction

    function automatic logic [24:0] mir_fields(input logic [40:0] w);
        return {w[40:35], w[34], w[33:28], w[27], w[26:21], w[20], w[17:14]};
    endfunction

    task automatic rand_flags();
        psr_nzvc = 4'($urandom);
        ir_bits  = $urandom;
    endtask

    // Run one microword starting at a negedge inside its LOAD cycle; returns
    // at the negedge of the following LOAD cycle. ACK arrives ack_late
    // cycles into WAIT; if that is WAIT_MAX or more the watchdog aborts.
    task automatic step_word(input int ack_late, input bit rnd);
        logic [40:0] w;
        logic [2:0]  req;
        int          n;
        bit          done;
        chk_eq("load_addr", 64'(cs_addr), 64'(m_csar));
        chk_eq("wd_err", 64'(wd_err), 64'(m_wd));
        if (rnd) rand_flags();
        mem_ack = 1'b1;                     // spurious, must be ignored
        #1;
        chk_eq("load_strobes", 64'({mem_rd, mem_wr, dp_en}), 64'(3'b000));
        w = rom[m_csar];
        @(negedge clk);
        mem_ack = 1'b1;                     // spurious, must be ignored
        #1;
        chk_eq("mir", 64'({mir_a, mir_amux, mir_b, mir_bmux, mir_c, mir_cmux, mir_alu}),
               64'(mir_fields(w)));
        if (!w[19] && !w[18]) begin
            chk_eq("exec_plain", 64'({mem_rd, mem_wr, dp_en}), 64'(3'b001));
            m_csar = ref_next(w, m_csar, psr_nzvc, ir_bits);
            @(negedge clk);
        end else begin
            req = {w[19], w[18] & ~w[19], 1'b0};
            chk_eq("exec_mem", 64'({mem_rd, mem_wr, dp_en}), 64'(req));
            n = 0;
            done = 1'b0;
            @(negedge clk);
            while (!done) begin
                if (rnd) rand_flags();
                mem_ack = (n == ack_late);
                #1;
                if (n == ack_late) begin
                    chk_eq("wait_ack", 64'({mem_rd, mem_wr, dp_en}), 64'(req | 3'b001));
                    m_csar = ref_next(w, m_csar, psr_nzvc, ir_bits);
                    done = 1'b1;
                end else begin
                    chk_eq("wait_hold", 64'({mem_rd, mem_wr, dp_en}), 64'(req));
                    if (n + 1 == c_WAIT_MAX) begin
                        m_csar = 11'd0;
                        m_wd   = 1'b1;
                        done   = 1'b1;
                    end
                end
                n++;
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        mem_ack  = 1'b0;
        psr_nzvc = 4'd0;
        ir_bits  = 32'd0;
        for (int i = 0; i < 2048; i++) rom[i] = mk_word(1'b0, 1'b0, 6'd0, 3'b110, 11'd0);
        rom[0]    = mk_word(1'b1, 1'b0, 6'd37, 3'b000, 11'd0);
        rom[1]    = mk_word(1'b0, 1'b0, 6'($urandom), 3'b111, 11'd0);
        rom[1600] = mk_word(1'b0, 1'b0, 6'($urandom), 3'b010, 11'd12);
        rom[11]   = mk_word(1'b0, 1'b0, 6'($urandom), 3'b110, 11'd10);
        rom[12]   = mk_word(1'b0, 1'b0, 6'($urandom), 3'b110, 11'd10);

        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_addr", 64'(cs_addr), 64'(0));
        chk_eq("rst_strobes", 64'({mem_rd, mem_wr, dp_en, wd_err}), 64'(0));
        chk_eq("rst_mir", 64'({mir_a, mir_amux, mir_b, mir_bmux, mir_c, mir_cmux, mir_alu}), 64'(0));
        rst_n  = 1'b1;
        m_csar = 11'd0;
        m_wd   = 1'b0;

        // Reset release: read word at 0, ACK late, then sequential address
        step_word(2, 1'b0);
        chk_eq("first_seq", 64'(cs_addr), 64'(1));

        // Instruction decode dispatch
        ir_bits = 32'h8080_0000;
        step_word(0, 1'b0);
        chk_eq("decode", 64'(cs_addr), 64'(1600));

        // Branch on z taken, then jump back to 10
        psr_nzvc = 4'b0100;
        step_word(0, 1'b0);
        chk_eq("branch_z_taken", 64'(cs_addr), 64'(12));
        step_word(0, 1'b0);

        // Each conditional branch, taken and not taken, from address 10
        for (int c = 1; c <= 5; c++) begin
            for (int t = 0; t < 2; t++) begin
                rom[10] = mk_word(1'b0, 1'b0, 6'($urandom), 3'(c), 11'd12);
                rand_flags();
                case (c)
                    1: psr_nzvc[3] = 1'(t);
                    2: psr_nzvc[2] = 1'(t);
                    3: psr_nzvc[1] = 1'(t);
                    4: psr_nzvc[0] = 1'(t);
                    default: ir_bits[13] = 1'(t);
                endcase
                step_word(0, 1'b0);
                chk_eq("branch", 64'(cs_addr), (t != 0) ? 64'(12) : 64'(11));
                step_word(0, 1'b1);
            end
        end

        // Wrap from the top of the control store and unconditional jump to 0
        rom[10]   = mk_word(1'b0, 1'b0, 6'($urandom), 3'b110, 11'd2047);
        rom[2047] = mk_word(1'b0, 1'b0, 6'($urandom), 3'b000, 11'd5);
        step_word(0, 1'b0);
        chk_eq("jump_top", 64'(cs_addr), 64'(2047));
        step_word(0, 1'b0);
        chk_eq("wrap", 64'(cs_addr), 64'(0));
        rom[0] = mk_word(1'b0, 1'b0, 6'($urandom), 3'b110, 11'd0);
        step_word(0, 1'b0);
        chk_eq("jump_zero", 64'(cs_addr), 64'(0));
        rom[0] = mk_word(1'b1, 1'b0, 6'd37, 3'b000, 11'd0);

        // Watchdog: ACK never arrives
        step_word(10, 1'b0);
        chk_eq("wd_set", 64'(wd_err), 64'(1));
        chk_eq("wd_addr", 64'(cs_addr), 64'(0));

        // Asynchronous reset in the middle of WAIT
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_eq("mid_wait_rd", 64'(mem_rd), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk_eq("async_strobes", 64'({mem_rd, mem_wr, dp_en}), 64'(0));
        chk_eq("async_wd", 64'(wd_err), 64'(0));
        chk_eq("async_addr", 64'(cs_addr), 64'(0));
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_csar = 11'd0;
        m_wd   = 1'b0;
        step_word(1, 1'b0);
        chk_eq("restart_seq", 64'(cs_addr), 64'(1));

        // Randomised microcode and inputs against the model
        for (int i = 0; i < 2048; i++) rom[i] = {9'($urandom), $urandom};
        for (int k = 0; k < 300; k++) begin
            step_word(($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
